// File: rtl/bootram_pkg.sv
// Shared types and constants for the boot RAM arbiter: FSM states, grant encoding, lane geometry.
package bootram_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned WORD_W    = NUM_LANES * LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LDR = 1'b1
    } gnt_e;

    // One RAM write beat: word data plus per-lane strobes (all-zero strobes = read).
    typedef struct packed {
        logic [WORD_W-1:0]    data;
        logic [NUM_LANES-1:0] strb;
    } wr_beat_t;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] lane);
        lane_onehot = NUM_LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/bootram_rr_arb.sv
// Two-way round-robin grant between CPU and loader; a tie goes to whoever was not granted last.
module bootram_rr_arb
    import bootram_pkg::*;
(
    input  logic cpu_req_i,
    input  logic ldr_req_i,
    input  logic last_gnt_i,
    output logic gnt_vld_c,
    output logic gnt_c
);

    always_comb begin
        gnt_vld_c = cpu_req_i | ldr_req_i;
        gnt_c     = GNT_CPU;
        if (cpu_req_i && ldr_req_i) begin
            gnt_c = (last_gnt_i == GNT_CPU) ? GNT_LDR : GNT_CPU;
        end else if (ldr_req_i) begin
            gnt_c = GNT_LDR;
        end
    end

endmodule

// File: rtl/bootram_arb.sv
// Arbitrates a 32-bit CPU port and a byte-wide loader port onto one 4-lane boot RAM.
// One access at a time: IDLE -> ISSUE -> (WAIT for reads) -> DONE -> IDLE.
module bootram_arb
    import bootram_pkg::*;
#(
    parameter int unsigned ADDR_W        = 11,
    parameter logic        LOCK_AT_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic [31:0]       cpu_rdata,
    input  logic              ldr_valid,
    output logic              ldr_ready,
    input  logic              ldr_we,
    input  logic [ADDR_W+1:0] ldr_addr,
    input  logic [7:0]        ldr_wdata,
    output logic [7:0]        ldr_rdata,
    input  logic              lock_set,
    output logic              locked,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic [3:0]        ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic [1:0]        lane_q, lane_d;
    logic              is_wr_q, is_wr_d;
    logic              locked_q, locked_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              ldr_ready_q, ldr_ready_d;
    logic              ram_ce_q, ram_ce_d;
    logic              ram_oce_q, ram_oce_d;
    logic [3:0]        ram_wre_q, ram_wre_d;
    logic [ADDR_W-1:0] ram_ad_q, ram_ad_d;
    logic [31:0]       ram_din_q, ram_din_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        ldr_rdata_q, ldr_rdata_d;

    logic              gnt_vld_c;
    logic              gnt_c;
    logic [ADDR_W-1:0] ad_sel_c;
    wr_beat_t          beat_c;
    logic              unused_addr_c;

    // Byte offset and bits above the RAM window are ignored on the CPU side.
    assign unused_addr_c = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    bootram_rr_arb u_rr_arb (
        .cpu_req_i  (cpu_valid),
        .ldr_req_i  (ldr_valid & ~locked_q),
        .last_gnt_i (last_gnt_q),
        .gnt_vld_c  (gnt_vld_c),
        .gnt_c      (gnt_c)
    );

    // Address and write beat of whichever requester is winning this cycle.
    always_comb begin
        ad_sel_c = ldr_addr[ADDR_W+1:2];
        beat_c   = '0;
        if (gnt_c == GNT_CPU) begin
            ad_sel_c    = cpu_addr[ADDR_W+1:2];
            beat_c.data = cpu_wdata;
            beat_c.strb = cpu_wstrb;
        end else begin
            beat_c.data = {NUM_LANES{ldr_wdata}};
            beat_c.strb = ldr_we ? lane_onehot(ldr_addr[1:0]) : 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (gnt_vld_c) state_d = ST_ISSUE;
            ST_ISSUE: state_d = is_wr_q ? ST_DONE : ST_WAIT;
            ST_WAIT:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed one state ahead so that the registered copy lines up with the state.
    always_comb begin
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        lane_d      = lane_q;
        is_wr_d     = is_wr_q;
        locked_d    = locked_q | lock_set;
        cpu_ready_d = 1'b0;
        ldr_ready_d = 1'b0;
        ram_ce_d    = 1'b0;
        ram_oce_d   = 1'b1;
        ram_wre_d   = 4'b0000;
        ram_ad_d    = ram_ad_q;
        ram_din_d   = ram_din_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld_c) begin
                    gnt_d     = gnt_c;
                    lane_d    = ldr_addr[1:0];
                    is_wr_d   = |beat_c.strb;
                    ram_ce_d  = 1'b1;
                    ram_ad_d  = ad_sel_c;
                    ram_din_d = beat_c.data;
                    ram_wre_d = beat_c.strb;
                end
            end
            ST_ISSUE: begin
                if (is_wr_q) begin
                    cpu_ready_d = (gnt_q == GNT_CPU);
                    ldr_ready_d = (gnt_q == GNT_LDR);
                end
            end
            ST_WAIT: begin
                cpu_ready_d = (gnt_q == GNT_CPU);
                ldr_ready_d = (gnt_q == GNT_LDR);
                if (gnt_q == GNT_CPU) begin
                    cpu_rdata_d = ram_dout;
                end else begin
                    ldr_rdata_d = ram_dout[LANE_W*lane_q +: LANE_W];
                end
            end
            ST_DONE: begin
                last_gnt_d = gnt_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gnt_q       <= GNT_CPU;
            last_gnt_q  <= GNT_LDR;
            lane_q      <= 2'b00;
            is_wr_q     <= 1'b0;
            locked_q    <= LOCK_AT_RESET;
            cpu_ready_q <= 1'b0;
            ldr_ready_q <= 1'b0;
            ram_ce_q    <= 1'b0;
            ram_oce_q   <= 1'b0;
            ram_wre_q   <= 4'b0000;
            ram_ad_q    <= '0;
            ram_din_q   <= 32'h0;
            cpu_rdata_q <= 32'h0;
            ldr_rdata_q <= 8'h0;
        end else begin
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            lane_q      <= lane_d;
            is_wr_q     <= is_wr_d;
            locked_q    <= locked_d;
            cpu_ready_q <= cpu_ready_d;
            ldr_ready_q <= ldr_ready_d;
            ram_ce_q    <= ram_ce_d;
            ram_oce_q   <= ram_oce_d;
            ram_wre_q   <= ram_wre_d;
            ram_ad_q    <= ram_ad_d;
            ram_din_q   <= ram_din_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign ldr_ready = ldr_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;
    assign locked    = locked_q;
    assign ram_ce    = ram_ce_q;
    assign ram_oce   = ram_oce_q;
    assign ram_wre   = ram_wre_q;
    assign ram_ad    = ram_ad_q;
    assign ram_din   = ram_din_q;

endmodule
